axi_mem_responder: RTL
======================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter NIC_ID_WIDTH, default 4: width of the AXI ID fields.
REQ-002 SHALL have parameter NIC_AWADDR_WD, default 32: width of the byte address.
REQ-003 SHALL have parameter NIC_W_WD, default 32: data width; only 32 is supported.
REQ-004 SHALL have parameter LGMEM, default 10: log2 of the memory depth in 32-bit words.
REQ-005 SHALL use one clock and an asynchronous active-low reset (already decided); ports as follows:
- S_AXI_ACLK  in  1  clock; all logic is rising-edge.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWVALID/AWREADY  in/out  1/1  AW handshake.
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  AW payload.
- S_AXI_AWLOCK/AWCACHE/AWPROT/AWQOS  in  1/4/3/4  accepted and ignored.
- S_AXI_WVALID/WREADY  in/out  1/1  W handshake.
- S_AXI_WDATA/WSTRB/WLAST  in  32/4/1  W payload.
- S_AXI_BVALID/BREADY  out/in  1/1  B handshake.
- S_AXI_BID/BRESP  out  ID/2  B payload.
- S_AXI_ARVALID/ARREADY  in/out  1/1  AR handshake.
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  AR payload.
- S_AXI_ARLOCK/ARCACHE/ARPROT/ARQOS  in  1/4/3/4  accepted and ignored.
- S_AXI_RVALID/RREADY  out/in  1/1  R handshake.
- S_AXI_RID/RDATA/RRESP/RLAST  out  ID/32/2/1  R payload.

Function
REQ-006 SHALL be an AXI4 slave backed by a 2^LGMEM x 32 register array; the read and write paths are independent and run concurrently.
REQ-007 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP:
- W_IDLE: AWREADY=1; an AW handshake latches ID, address, length, burst and error flag, then moves to W_DATA.
- W_DATA: WREADY=1; one beat is written per W handshake; the beat with WLAST=1, or beat number AWLEN+1, moves to W_RESP.
- W_RESP: BVALID=1; the BVALID&&BREADY handshake returns to W_IDLE.
REQ-008 AWREADY SHALL be 0 outside W_IDLE and WREADY SHALL be 0 outside W_DATA; at most one write burst is outstanding.
REQ-009 Read FSM SHALL have states R_IDLE and R_DATA:
- R_IDLE: ARREADY=1; an AR handshake latches the burst and moves to R_DATA.
- R_DATA: the first RVALID is registered and appears the cycle after the AR handshake.
REQ-010 In R_DATA the read path SHALL present one beat per cycle while RREADY=1, and SHALL hold all R outputs stable while RVALID=1 && RREADY=0.
REQ-011 RLAST SHALL be 1 on beat ARLEN+1 only; the handshake on that beat SHALL return the read FSM to R_IDLE, with ARREADY high the following cycle.
REQ-012 Beat addressing:
- INCR: address increments by 4 per beat.
- FIXED: every beat uses the start address.
- WRAP and reserved burst types: treated as INCR and flagged as errors.
- Word index = address[LGMEM+1:2]; it wraps modulo 2^LGMEM.
REQ-013 A burst SHALL be flagged as an error if any of these hold: address bits above LGMEM+1 nonzero, AxSIZE != 2, or burst type WRAP or 3.
REQ-014 An errored write SHALL suppress all array writes and return BRESP=SLVERR (2); an errored read SHALL return RDATA=0 and RRESP=SLVERR on every beat; otherwise responses SHALL be OKAY (0).
REQ-015 BID SHALL equal the latched AWID, and RID SHALL equal the latched ARID.
REQ-016 If WLAST arrives before beat AWLEN+1, the burst SHALL be terminated and BRESP=SLVERR; if WLAST is missing on beat AWLEN+1, the write FSM SHALL still move to W_RESP with BRESP=SLVERR.
REQ-017 A same-cycle read and write to the same word SHALL return the old data.

Reset
REQ-018 On S_AXI_ARESETN=0 the block SHALL immediately force both FSMs to their idle states and drive:
- AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0.
- BID=0, BRESP=0, RID=0, RRESP=0, RDATA=0.
REQ-019 AWREADY and ARREADY SHALL rise on the first clock edge after reset deasserts.
REQ-020 Reset SHALL NOT clear array contents, and a burst in flight at reset SHALL be abandoned without a response.

Configuration
REQ-021 SHALL support macro AXI_MEM_STRB_EN:
- Defined: each byte lane is written only where WSTRB[i]=1.
- Undefined: WSTRB is ignored and every accepted beat writes the full word.

Verification
REQ-022 Write INCR AWADDR=0x10, AWLEN=3, data 1..4 -> words 4..7 = 1..4; BRESP=0 and BID=AWID.
REQ-023 Read back AR 0x10, AWLEN=3 with RREADY low for 2 cycles on beat 2 -> RDATA 1,2,3,4 stable while stalled; RLAST on beat 4 only; first RVALID 1 cycle after AR.
REQ-024 AWADDR=0x8000_0000 -> no array change, BRESP=2; ARSIZE=1 -> every beat RRESP=2, RDATA=0.
REQ-025 With AXI_MEM_STRB_EN, word 0 = 0xFFFF_FFFF then write 0x1234_5678 with WSTRB=0x3 -> read returns 0xFFFF_5678; without the macro -> read returns 0x1234_5678.
REQ-026 Deassert S_AXI_ARESETN mid read burst at beat 2 -> RVALID=0 in the same cycle; ARREADY=1 one edge after release; a new read returns correct data.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a 2^LGMEM x 32 register array; read and write paths run concurrently.
// Optional macro AXI_MEM_STRB_EN: honour WSTRB byte lanes (otherwise every accepted beat writes the full word).
module axi_mem_responder #(
  parameter int NIC_ID_WIDTH  = 4,
  parameter int NIC_AWADDR_WD = 32,
  parameter int NIC_W_WD      = 32,
  parameter int LGMEM         = 10
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [NIC_ID_WIDTH-1:0]  S_AXI_AWID,
  input  logic [NIC_AWADDR_WD-1:0] S_AXI_AWADDR,
  input  logic [7:0]               S_AXI_AWLEN,
  input  logic [2:0]               S_AXI_AWSIZE,
  input  logic [1:0]               S_AXI_AWBURST,
  input  logic                     S_AXI_AWLOCK,
  input  logic [3:0]               S_AXI_AWCACHE,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic [3:0]               S_AXI_AWQOS,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  input  logic [NIC_W_WD-1:0]      S_AXI_WDATA,
  input  logic [NIC_W_WD/8-1:0]    S_AXI_WSTRB,
  input  logic                     S_AXI_WLAST,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  output logic [NIC_ID_WIDTH-1:0]  S_AXI_BID,
  output logic [1:0]               S_AXI_BRESP,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  input  logic [NIC_ID_WIDTH-1:0]  S_AXI_ARID,
  input  logic [NIC_AWADDR_WD-1:0] S_AXI_ARADDR,
  input  logic [7:0]               S_AXI_ARLEN,
  input  logic [2:0]               S_AXI_ARSIZE,
  input  logic [1:0]               S_AXI_ARBURST,
  input  logic                     S_AXI_ARLOCK,
  input  logic [3:0]               S_AXI_ARCACHE,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic [3:0]               S_AXI_ARQOS,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NIC_ID_WIDTH-1:0]  S_AXI_RID,
  output logic [NIC_W_WD-1:0]      S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RLAST
);
  localparam int DEPTH  = 1 << LGMEM;
  localparam int NBYTES = NIC_W_WD / 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [NIC_ID_WIDTH-1:0] id;
    logic [LGMEM-1:0]        idx;
    logic [7:0]              len;
    logic                    fixed;
    logic                    err;
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [NIC_W_WD-1:0] mem [DEPTH];

  // Address decode: out-of-range upper bits, non-word size and WRAP/reserved bursts all error out
  logic   aw_err, ar_err;
  burst_t aw_dec, ar_dec;
  assign aw_err = (|S_AXI_AWADDR[NIC_AWADDR_WD-1:LGMEM+2]) || (S_AXI_AWSIZE != 3'd2) || S_AXI_AWBURST[1];
  assign ar_err = (|S_AXI_ARADDR[NIC_AWADDR_WD-1:LGMEM+2]) || (S_AXI_ARSIZE != 3'd2) || S_AXI_ARBURST[1];
  assign aw_dec = {S_AXI_AWID, S_AXI_AWADDR[LGMEM+1:2], S_AXI_AWLEN, S_AXI_AWBURST == 2'b00, aw_err};
  assign ar_dec = {S_AXI_ARID, S_AXI_ARADDR[LGMEM+1:2], S_AXI_ARLEN, S_AXI_ARBURST == 2'b00, ar_err};

  // ---------------- write path ----------------
  wstate_t    wstate;
  burst_t     wb;
  logic [7:0] wbeat;
  logic       w_hs, w_final;

  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign w_final = S_AXI_WLAST || (wbeat == wb.len);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate        <= W_IDLE;
      wb            <= '0;
      wbeat         <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BID     <= '0;
      S_AXI_BRESP   <= OKAY;
    end else begin
      case (wstate)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            wb            <= aw_dec;
            wbeat         <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wbeat <= wbeat + 8'd1;
            if (!wb.fixed) wb.idx <= wb.idx + 1'b1;
            if (w_final) begin
              // WLAST must coincide exactly with beat AWLEN+1, early or missing is a protocol error
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BID    <= wb.id;
              S_AXI_BRESP  <= (wb.err || (S_AXI_WLAST != (wbeat == wb.len))) ? SLVERR : OKAY;
              wstate       <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  logic [NBYTES-1:0] wbe;
  logic              we;
`ifdef AXI_MEM_STRB_EN
  assign wbe = S_AXI_WSTRB;
`else
  assign wbe = '1;
`endif
  assign we = w_hs && !wb.err;

  // Array has no reset so contents survive S_AXI_ARESETN
  always_ff @(posedge S_AXI_ACLK) begin
    if (we)
      for (int b = 0; b < NBYTES; b++)
        if (wbe[b]) mem[wb.idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
  end

  // ---------------- read path ----------------
  rstate_t          rstate;
  burst_t           rb;
  logic [7:0]       rbeat;
  logic [LGMEM-1:0] r_nidx;

  assign r_nidx = rb.fixed ? rb.idx : rb.idx + 1'b1;

  // Data is fetched at the handshake edge, so a same-edge write to that word is not seen
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate        <= R_IDLE;
      rb            <= '0;
      rbeat         <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RID     <= '0;
      S_AXI_RRESP   <= OKAY;
      S_AXI_RDATA   <= '0;
    end else if (rstate == R_IDLE) begin
      S_AXI_ARREADY <= 1'b1;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        rb            <= ar_dec;
        rbeat         <= '0;
        S_AXI_ARREADY <= 1'b0;
        S_AXI_RVALID  <= 1'b1;
        S_AXI_RID     <= ar_dec.id;
        S_AXI_RRESP   <= ar_dec.err ? SLVERR : OKAY;
        S_AXI_RDATA   <= ar_dec.err ? '0 : mem[ar_dec.idx];
        S_AXI_RLAST   <= (ar_dec.len == 8'd0);
        rstate        <= R_DATA;
      end
    end else if (S_AXI_RREADY) begin
      if (S_AXI_RLAST) begin
        S_AXI_RVALID  <= 1'b0;
        S_AXI_RLAST   <= 1'b0;
        S_AXI_ARREADY <= 1'b1;
        rstate        <= R_IDLE;
      end else begin
        rb.idx      <= r_nidx;
        rbeat       <= rbeat + 8'd1;
        S_AXI_RDATA <= rb.err ? '0 : mem[r_nidx];
        S_AXI_RLAST <= ((rbeat + 8'd1) == rb.len);
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                       S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB};

endmodule
